// File: rtl/zy_pkg.sv
// Shared types and sizing for the execute stage: ALU opcodes and the
// iterative multiplier state encoding.
package zy_pkg;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_EQ    = 4'd10,
    ALU_NE    = 4'd11,
    ALU_MUL   = 4'd12,
    ALU_MULHU = 4'd13,
    ALU_PASSB = 4'd14,
    ALU_RSVD  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul_op(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Unsigned shift-add multiplier retiring one multiplier bit per cycle;
// IDLE latches operands, BUSY iterates, DONE presents the 64-bit product.
module ex_mul_iter
  import zy_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_flush,
  input  logic [XLEN-1:0]     i_a,
  input  logic [XLEN-1:0]     i_b,
  output logic                o_busy,
  output logic                o_done,
  output logic [2*XLEN-1:0]   o_prod
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  mul_state_t          r_state;
  mul_state_t          w_nextState;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MUL_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MUL_IDLE: if (i_start && !i_flush) w_nextState = MUL_BUSY;
      MUL_BUSY: begin
        if (i_flush)                w_nextState = MUL_IDLE;
        else if (r_cnt == LAST_CNT) w_nextState = MUL_DONE;
      end
      MUL_DONE: w_nextState = MUL_IDLE;
      default:  w_nextState = MUL_IDLE;
    endcase
  end

  // The multiplicand walks left while the multiplier walks right; each set
  // multiplier bit adds the current multiplicand into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (r_state == MUL_IDLE && i_start && !i_flush) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{XLEN{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_state == MUL_BUSY && !i_flush) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign o_busy = (r_state == MUL_BUSY);
  assign o_done = (r_state == MUL_DONE);
  assign o_prod = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump redirect and the registered EX/MEM boundary.
// Define ZY_EX_MUL_EN to build the iterative multiplier for MUL/MULHU.
module ex_stage
  import zy_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rdata1,
  input  logic [XLEN-1:0] ex_rdata2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [3:0]      ex_alu_op,
  input  logic            ex_alusrc,
  input  logic            ex_regw,
  input  logic            ex_memr,
  input  logic            ex_memw,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [4:0]      ex_rd,
  output logic            ex_stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mem_alu_res,
  output logic [XLEN-1:0] mem_wdata,
  output logic [4:0]      mem_rd,
  output logic            mem_regw,
  output logic            mem_memr,
  output logic            mem_memw
);

  alu_op_t         w_op;
  logic [XLEN-1:0] w_opB;
  logic [XLEN-1:0] w_aluRes;
  logic [XLEN-1:0] w_pcPlus4;
  logic [XLEN-1:0] w_brTarget;
  logic [XLEN-1:0] w_jalrTarget;
  logic            w_taken;
  logic            w_bubble;

  assign w_op  = alu_op_t'(ex_alu_op);
  assign w_opB = ex_alusrc ? ex_imm : ex_rdata2;

`ifdef ZY_EX_MUL_EN
  logic              w_mulStart;
  logic              w_mulBusy;
  logic              w_mulDone;
  logic [2*XLEN-1:0] w_mulProd;

  assign w_mulStart = is_mul_op(w_op) & ~flush;

  ex_mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mulStart),
    .i_flush (flush),
    .i_a     (ex_rdata1),
    .i_b     (w_opB),
    .o_busy  (w_mulBusy),
    .o_done  (w_mulDone),
    .o_prod  (w_mulProd)
  );

  // Stall covers the launch cycle in IDLE plus every BUSY cycle; DONE releases.
  assign ex_stall = w_mulBusy | (w_mulStart & ~w_mulDone);
`else
  assign ex_stall = 1'b0;
`endif

  always_comb begin
    w_aluRes = '0;
    case (w_op)
      ALU_ADD:   w_aluRes = ex_rdata1 + w_opB;
      ALU_SUB:   w_aluRes = ex_rdata1 - w_opB;
      ALU_AND:   w_aluRes = ex_rdata1 & w_opB;
      ALU_OR:    w_aluRes = ex_rdata1 | w_opB;
      ALU_XOR:   w_aluRes = ex_rdata1 ^ w_opB;
      ALU_SLL:   w_aluRes = ex_rdata1 << w_opB[4:0];
      ALU_SRL:   w_aluRes = ex_rdata1 >> w_opB[4:0];
      ALU_SRA:   w_aluRes = $signed(ex_rdata1) >>> w_opB[4:0];
      ALU_SLT:   w_aluRes = {{(XLEN-1){1'b0}}, ($signed(ex_rdata1) < $signed(w_opB))};
      ALU_SLTU:  w_aluRes = {{(XLEN-1){1'b0}}, (ex_rdata1 < w_opB)};
      ALU_EQ:    w_aluRes = {{(XLEN-1){1'b0}}, (ex_rdata1 == w_opB)};
      ALU_NE:    w_aluRes = {{(XLEN-1){1'b0}}, (ex_rdata1 != w_opB)};
`ifdef ZY_EX_MUL_EN
      ALU_MUL:   w_aluRes = w_mulProd[XLEN-1:0];
      ALU_MULHU: w_aluRes = w_mulProd[2*XLEN-1:XLEN];
`else
      ALU_MUL:   w_aluRes = '0;
      ALU_MULHU: w_aluRes = '0;
`endif
      ALU_PASSB: w_aluRes = w_opB;
      ALU_RSVD:  w_aluRes = '0;
      default:   w_aluRes = '0;
    endcase
  end

  assign w_pcPlus4    = ex_pc + 32'd4;
  assign w_brTarget   = ex_pc + ex_imm;
  assign w_jalrTarget = (ex_rdata1 + ex_imm) & ~32'd1;

  assign w_taken        = (ex_branch & w_aluRes[0]) | ex_jump;
  assign redirect_valid = w_taken & ~flush & ~ex_stall;
  assign redirect_pc    = (ex_jump & ex_alusrc) ? w_jalrTarget : w_brTarget;

  assign w_bubble = flush | ex_stall;

  // A killed or stalled instruction leaves a fully zeroed slot in EX/MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_bubble) begin
      mem_alu_res <= '0;
      mem_wdata   <= '0;
      mem_rd      <= '0;
      mem_regw    <= 1'b0;
      mem_memr    <= 1'b0;
      mem_memw    <= 1'b0;
    end else begin
      mem_alu_res <= ex_jump ? w_pcPlus4 : w_aluRes;
      mem_wdata   <= ex_rdata2;
      mem_rd      <= ex_rd;
      mem_regw    <= ex_regw & (ex_rd != 5'd0);
      mem_memr    <= ex_memr;
      mem_memw    <= ex_memw;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; expectations come from a plain-arithmetic
// reference model. Follows ZY_EX_MUL_EN the same way the design does.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [3:0]  ex_alu_op;
  logic        ex_alusrc, ex_regw, ex_memr, ex_memw, ex_branch, ex_jump;
  logic [4:0]  ex_rd;
  logic        ex_stall, redirect_valid;
  logic [31:0] redirect_pc, mem_alu_res, mem_wdata;
  logic [4:0]  mem_rd;
  logic        mem_regw, mem_memr, mem_memw;

  int errors = 0;
  int checks = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alusrc(ex_alusrc), .ex_regw(ex_regw),
    .ex_memr(ex_memr), .ex_memw(ex_memw), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_rd(ex_rd), .ex_stall(ex_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_alu_res(mem_alu_res), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_regw(mem_regw), .mem_memr(mem_memr), .mem_memw(mem_memw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    p  = 64'(a) * 64'(b);
    sa = a;
    sb = b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return 32'(sa >>> b[4:0]);
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return (a == b) ? 32'd1 : 32'd0;
      4'd11: return (a != b) ? 32'd1 : 32'd0;
`ifdef ZY_EX_MUL_EN
      4'd12: return p[31:0];
      4'd13: return p[63:32];
`endif
      4'd14: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [31:0] pc, r1, r2, imm, input logic [3:0] op,
                               input logic alusrc, regw, memr, memw, branch, jump,
                               input logic [4:0] rd);
    ex_pc = pc; ex_rdata1 = r1; ex_rdata2 = r2; ex_imm = imm; ex_alu_op = op;
    ex_alusrc = alusrc; ex_regw = regw; ex_memr = memr; ex_memw = memw;
    ex_branch = branch; ex_jump = jump; ex_rd = rd;
  endtask

  task automatic applyBubble();
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    applyStimulus(32'h10, 32'd3, 32'd4, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_alu_res !== 32'd0) begin errors++; $display("[TB] FAIL reset.alu_res got=%h exp=0", mem_alu_res); end
    checks++; if ({mem_regw, mem_memr, mem_memw} !== 3'b000) begin errors++; $display("[TB] FAIL reset.ctrl got=%b exp=000", {mem_regw, mem_memr, mem_memw}); end
    checks++; if (mem_rd !== 5'd0 || mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset.rd_wdata got=%0d/%h exp=0/0", mem_rd, mem_wdata); end
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset.stall got=%b exp=0", ex_stall); end
    rst = 1'b0;
    applyBubble();
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    applyStimulus(32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    @(posedge clk); #1;
    checks++; if (mem_alu_res !== 32'd0) begin errors++; $display("[TB] FAIL add_wrap.res got=%h exp=0", mem_alu_res); end
    checks++; if (mem_rd !== 5'd5) begin errors++; $display("[TB] FAIL add_wrap.rd got=%0d exp=5", mem_rd); end
    checks++; if (mem_regw !== 1'b1) begin errors++; $display("[TB] FAIL add_wrap.regw got=%b exp=1", mem_regw); end
    checks++; if (mem_wdata !== 32'd1) begin errors++; $display("[TB] FAIL add_wrap.wdata got=%h exp=1", mem_wdata); end
  endtask

  task automatic test_branch_jump();
    applyStimulus(32'h100, 32'd7, 32'd7, 32'h20, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq.valid got=%b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("[TB] FAIL beq.pc got=%h exp=120", redirect_pc); end
    @(posedge clk); #1;
    checks++; if (mem_regw !== 1'b0) begin errors++; $display("[TB] FAIL beq.regw got=%b exp=0", mem_regw); end
    // JALR clears bit 0 of the target; link is pc+4
    applyStimulus(32'h40, 32'h203, 32'd0, 32'd4, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h206) begin errors++; $display("[TB] FAIL jalr.redirect got=%b/%h exp=1/206", redirect_valid, redirect_pc); end
    @(posedge clk); #1;
    checks++; if (mem_alu_res !== 32'h44 || mem_regw !== 1'b1) begin errors++; $display("[TB] FAIL jalr.link got=%h/%b exp=44/1", mem_alu_res, mem_regw); end
    applyStimulus(32'h40, 32'h203, 32'd0, 32'h100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
    #1;
    checks++; if (redirect_pc !== 32'h140) begin errors++; $display("[TB] FAIL jal.pc got=%h exp=140", redirect_pc); end
    // not-taken branch: NE on equal operands
    applyStimulus(32'h100, 32'd7, 32'd7, 32'h20, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL bne_nt.valid got=%b exp=0", redirect_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_rd_zero_and_flush();
    applyStimulus(32'h0, 32'd10, 32'd20, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++; if (mem_regw !== 1'b0 || mem_alu_res !== 32'd30) begin errors++; $display("[TB] FAIL rd_zero got=%b/%h exp=0/1e", mem_regw, mem_alu_res); end
    flush = 1'b1;
    applyStimulus(32'h80, 32'd5, 32'd5, 32'h10, 4'd10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush.redirect got=%b exp=0", redirect_valid); end
    @(posedge clk); #1;
    checks++; if ({mem_regw, mem_memr, mem_memw} !== 3'b000 || mem_alu_res !== 32'd0 || mem_rd !== 5'd0) begin
      errors++; $display("[TB] FAIL flush.bubble got=%b/%h/%0d exp=000/0/0", {mem_regw, mem_memr, mem_memw}, mem_alu_res, mem_rd);
    end
    flush = 1'b0;
  endtask

  task automatic test_random_alu();
    logic [31:0] pc, a, b2, imm, bval, res, expRes, expPc;
    logic [3:0]  op;
    logic        as, br, jp, rw, mr, mw, fl, expRv;
    logic [4:0]  rd;
    for (int i = 0; i < 80; i++) begin
      pc = $urandom & 32'hFFFF_FFFC; a = $urandom; b2 = $urandom;
      imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom;
      op = 4'($urandom_range(0, 15));
`ifdef ZY_EX_MUL_EN
      if (op == 4'd12 || op == 4'd13) op = 4'd14;
`endif
      if ($urandom_range(0, 3) == 0) b2 = a;
      as = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      jp = ~br & ($urandom_range(0, 3) == 0); rw = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 7) == 0); rd = 5'($urandom_range(0, 31));
      flush = fl;
      applyStimulus(pc, a, b2, imm, op, as, rw, mr, mw, br, jp, rd);
      bval   = as ? imm : b2;
      res    = refAlu(op, a, bval);
      expRv  = ((br && res[0]) || jp) && !fl;
      expPc  = (jp && as) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
      expRes = fl ? 32'd0 : (jp ? pc + 32'd4 : res);
      #1;
      checks++; if (redirect_valid !== expRv || ex_stall !== 1'b0) begin errors++; $display("[TB] FAIL rand[%0d].redirect got=%b stall=%b exp=%b", i, redirect_valid, ex_stall, expRv); end
      if (expRv) begin
        checks++; if (redirect_pc !== expPc) begin errors++; $display("[TB] FAIL rand[%0d].pc got=%h exp=%h", i, redirect_pc, expPc); end
      end
      @(posedge clk); #1;
      checks++; if (mem_alu_res !== expRes) begin errors++; $display("[TB] FAIL rand[%0d].res op=%0d got=%h exp=%h", i, op, mem_alu_res, expRes); end
      checks++; if (mem_regw !== (!fl && rw && rd != 5'd0) || mem_memr !== (!fl && mr) || mem_memw !== (!fl && mw)) begin
        errors++; $display("[TB] FAIL rand[%0d].ctrl got=%b%b%b", i, mem_regw, mem_memr, mem_memw);
      end
      checks++; if (mem_rd !== (fl ? 5'd0 : rd) || mem_wdata !== (fl ? 32'd0 : b2)) begin
        errors++; $display("[TB] FAIL rand[%0d].rd_wdata got=%0d/%h", i, mem_rd, mem_wdata);
      end
    end
    flush = 1'b0;
    applyBubble();
  endtask

  task automatic test_mul_back_to_back();
`ifdef ZY_EX_MUL_EN
    logic [31:0] ta[5], tb2[5], texp[5];
    logic [3:0]  top[5];
    logic        tas[5];
    int          n;
    ta[0] = 32'h1234_5678; tb2[0] = 32'h10;        top[0] = 4'd12; tas[0] = 1'b0; texp[0] = 32'h2345_6780;
    ta[1] = 32'hFFFF_FFFF; tb2[1] = 32'hFFFF_FFFF; top[1] = 4'd13; tas[1] = 1'b0; texp[1] = 32'hFFFF_FFFE;
    for (int k = 2; k < 5; k++) begin
      ta[k] = $urandom; tb2[k] = $urandom; top[k] = (k == 3) ? 4'd13 : 4'd12; tas[k] = (k == 4);
      texp[k] = refAlu(top[k], ta[k], tb2[k]);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(32'h200, ta[k], tas[k] ? ~tb2[k] : tb2[k], tas[k] ? tb2[k] : 32'h0, top[k],
                    tas[k], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7);
      #1;
      n = 0;
      while (ex_stall === 1'b1 && n < 100) begin
        n++;
        checks++; if (mem_regw !== 1'b0) begin errors++; $display("[TB] FAIL mul[%0d].early_wb cycle=%0d", k, n); end
        @(posedge clk); #1;
      end
      checks++; if (n != 33) begin errors++; $display("[TB] FAIL mul[%0d].stall_cycles got=%0d exp=33", k, n); end
      @(posedge clk); #1;
      checks++; if (mem_alu_res !== texp[k] || mem_regw !== 1'b1) begin errors++; $display("[TB] FAIL mul[%0d].res got=%h/%b exp=%h/1", k, mem_alu_res, mem_regw, texp[k]); end
    end
    applyBubble();
    @(posedge clk); #1;
`else
    for (int k = 0; k < 2; k++) begin
      applyStimulus(32'h200, 32'h1234_5678, 32'h10, 32'd0, 4'd12 + 4'(k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7);
      #1;
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("[TB] FAIL nomul[%0d].stall got=%b exp=0", k, ex_stall); end
      @(posedge clk); #1;
      checks++; if (mem_alu_res !== 32'd0 || mem_regw !== 1'b1) begin errors++; $display("[TB] FAIL nomul[%0d].res got=%h/%b exp=0/1", k, mem_alu_res, mem_regw); end
    end
    applyBubble();
`endif
  endtask

  task automatic test_mul_abort();
`ifdef ZY_EX_MUL_EN
    logic bad;
    applyStimulus(32'h300, 32'd9, 32'd9, 32'd0, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
    repeat (11) @(posedge clk);
    #1;
    checks++; if (ex_stall !== 1'b1) begin errors++; $display("[TB] FAIL mulflush.busy got=%b exp=1", ex_stall); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    applyBubble();
    #1;
    checks++; if (ex_stall !== 1'b0 || mem_regw !== 1'b0) begin errors++; $display("[TB] FAIL mulflush.idle got=%b/%b exp=0/0", ex_stall, mem_regw); end
    bad = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      if (ex_stall !== 1'b0 || mem_regw !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("[TB] FAIL mulflush.no_wb got=%b exp=0", bad); end
    applyStimulus(32'h300, 32'd9, 32'd9, 32'd0, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    applyBubble();
    #1;
    checks++; if (ex_stall !== 1'b0 || mem_alu_res !== 32'd0 || mem_regw !== 1'b0) begin errors++; $display("[TB] FAIL mulrst.state got=%b/%h exp=0/0", ex_stall, mem_alu_res); end
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    applyStimulus(32'h0, 32'd100, 32'd23, 32'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
    @(posedge clk); #1;
    checks++; if (mem_alu_res !== 32'd77 || mem_regw !== 1'b1) begin errors++; $display("[TB] FAIL async_rst.pre got=%h/%b exp=4d/1", mem_alu_res, mem_regw); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mem_alu_res !== 32'd0 || mem_regw !== 1'b0 || mem_rd !== 5'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("[TB] FAIL async_rst.clear got=%h/%b/%0d/%h exp=0", mem_alu_res, mem_regw, mem_rd, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyBubble();
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_branch_jump();
    test_rd_zero_and_flush();
    test_random_alu();
    test_mul_back_to_back();
    test_mul_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
